// File: rtl/gain_unit_scheduler.sv
// gain_unit_scheduler: walks the enabled channels of one frame snapshot
// through the shared gain unit, with a watchdog on each transaction.
module gain_unit_scheduler #(
   parameter int NCH     = 4,
   parameter int TIMEOUT = 255
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              sample_ready,
   input  logic [NCH*32-1:0] samples_in,
   input  logic [NCH-1:0]    ch_enable,
   input  logic              clear_err,
   input  logic              unit_idle,
   input  logic              unit_fin,
   input  logic [31:0]       unit_result,
   output logic              unit_start,
   output logic [31:0]       unit_operand,
   output logic [1:0]        unit_chan,
   output logic [NCH*32-1:0] results_out,
   output logic              results_valid,
   output logic              busy,
   output logic              overrun,
   output logic              timeout_err
);

   localparam int CW = 2;
   localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_FIN,
      DONE
   } state_t;

   state_t            state_q, state_d;
   logic [NCH*32-1:0] snap_q, snap_d;
   logic [NCH-1:0]    mask_q, mask_d;
   logic [CW-1:0]     ch_q, ch_d;
   logic [7:0]        wd_q, wd_d;
   logic [NCH*32-1:0] res_q, res_d;
   logic              ovr_q, ovr_d;
   logic              to_q, to_d;

   logic              first_ok;
   logic [CW-1:0]     first_c;
   logic              next_ok;
   logic [CW-1:0]     next_c;
   logic              adv;

   // Lowest enabled channel of the incoming mask, and the next one above ch.
   always_comb begin
      first_ok = 1'b0;
      first_c  = '0;
      next_ok  = 1'b0;
      next_c   = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (ch_enable[i]) begin
            first_ok = 1'b1;
            first_c  = CW'(i);
         end
         if (mask_q[i] && (i > int'(ch_q))) begin
            next_ok = 1'b1;
            next_c  = CW'(i);
         end
      end
   end

   // Next-state logic: sequencing, watchdog, result capture, sticky errors.
   always_comb begin
      state_d    = state_q;
      snap_d     = snap_q;
      mask_d     = mask_q;
      ch_d       = ch_q;
      wd_d       = wd_q;
      res_d      = res_q;
      ovr_d      = ovr_q;
      to_d       = to_q;
      unit_start = 1'b0;
      adv        = 1'b0;

      if (clear_err) begin
         ovr_d = 1'b0;
         to_d  = 1'b0;
      end
      if (sample_ready && (state_q != IDLE)) begin
         ovr_d = 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            if (sample_ready) begin
               snap_d = samples_in;
               mask_d = ch_enable;
               if (first_ok) begin
                  ch_d    = first_c;
                  state_d = ISSUE;
               end else begin
                  state_d = DONE;
               end
            end
         end
         ISSUE: begin
            if (unit_idle) begin
               unit_start = 1'b1;
               wd_d       = '0;
               state_d    = WAIT_FIN;
            end
         end
         WAIT_FIN: begin
            if (unit_fin) begin
               res_d[32*int'(ch_q) +: 32] = unit_result;
               adv = 1'b1;
            end else if (wd_q == WD_LAST) begin
               to_d = 1'b1;
               adv  = 1'b1;
            end else begin
               wd_d = wd_q + 8'd1;
            end
            if (adv) begin
               if (next_ok) begin
                  ch_d    = next_c;
                  state_d = ISSUE;
               end else begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= IDLE;
         snap_q  <= '0;
         mask_q  <= '0;
         ch_q    <= '0;
         wd_q    <= '0;
         res_q   <= '0;
         ovr_q   <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         snap_q  <= snap_d;
         mask_q  <= mask_d;
         ch_q    <= ch_d;
         wd_q    <= wd_d;
         res_q   <= res_d;
         ovr_q   <= ovr_d;
         to_q    <= to_d;
      end
   end

   logic act;
   assign act           = (state_q == ISSUE) || (state_q == WAIT_FIN);
   assign unit_chan     = act ? ch_q : '0;
   assign unit_operand  = act ? snap_q[32*int'(ch_q) +: 32] : '0;
   assign results_out   = res_q;
   assign results_valid = (state_q == DONE);
   assign busy          = (state_q != IDLE);
   assign overrun       = ovr_q;
   assign timeout_err   = to_q;

endmodule

// File: tb/tb_gain_unit_scheduler.sv
// Directed bench for gain_unit_scheduler with a small gain-unit model
// returning 2x operand a fixed latency after each start.
module tb_gain_unit_scheduler;

   localparam int TO = 8;

   logic         CLK = 1'b0;
   logic         RESET = 1'b1;
   logic         sample_ready = 1'b0;
   logic [127:0] samples_in = '0;
   logic [3:0]   ch_enable = '0;
   logic         clear_err = 1'b0;
   logic         unit_idle = 1'b1;
   logic         unit_fin;
   logic [31:0]  unit_result;
   logic         unit_start;
   logic [31:0]  unit_operand;
   logic [1:0]   unit_chan;
   logic [127:0] results_out;
   logic         results_valid;
   logic         busy;
   logic         overrun;
   logic         timeout_err;

   always #5 CLK = ~CLK;

   gain_unit_scheduler #(.NCH(4), .TIMEOUT(TO)) dut (
      .CLK(CLK), .RESET(RESET), .sample_ready(sample_ready),
      .samples_in(samples_in), .ch_enable(ch_enable),
      .clear_err(clear_err), .unit_idle(unit_idle),
      .unit_fin(unit_fin), .unit_result(unit_result),
      .unit_start(unit_start), .unit_operand(unit_operand),
      .unit_chan(unit_chan), .results_out(results_out),
      .results_valid(results_valid), .busy(busy),
      .overrun(overrun), .timeout_err(timeout_err)
   );

   // gain unit model
   logic        m_fin = 1'b0;
   logic [31:0] m_res = '0;
   logic        f_fin = 1'b0;
   logic [31:0] f_res = '0;
   int          lat = 3;
   int          cnt = 0;
   logic        sup_en = 1'b0;
   logic [1:0]  sup_ch = 2'd2;
   logic [1:0]  m_ch = '0;
   logic [31:0] m_op = '0;

   assign unit_fin    = m_fin | f_fin;
   assign unit_result = f_fin ? f_res : m_res;

   always @(posedge CLK) begin
      #2;
      m_fin = 1'b0;
      if (cnt > 0) begin
         cnt--;
         if (cnt == 0 && !(sup_en && m_ch == sup_ch)) begin
            m_fin = 1'b1;
            m_res = m_op << 1;
         end
      end
      if (unit_start) begin
         cnt  = lat;
         m_ch = unit_chan;
         m_op = unit_operand;
      end
   end

   int vec = 0;
   int miss = 0;

   task automatic check(input string tag, input logic [127:0] obs,
                        input logic [127:0] exp);
      vec++;
      assert (obs === exp) else begin
         miss++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic mid();
      @(negedge CLK);
   endtask

   int         vcyc, nstart, busycnt, wf2;
   logic [7:0] chseq;
   logic [31:0] op0;
   int         st[$];
   int         idle_a = -1;
   int         idle_b = -1;
   int         ovr_cyc = -1;
   logic       ovr_clr = 1'b0;

   function automatic int st_at(input int k);
      return (st.size() > k) ? st[k] : -1;
   endfunction

   task automatic run_frame(input logic [127:0] s, input logic [3:0] m,
                            input int maxc);
      vcyc = -1; nstart = 0; busycnt = 0; wf2 = 0;
      chseq = '0; op0 = '0; st.delete();
      step();
      sample_ready = 1'b1;
      samples_in   = s;
      ch_enable    = m;
      for (int c = 1; c <= maxc; c++) begin
         step();
         sample_ready = (c == ovr_cyc);
         clear_err    = ovr_clr && (c == ovr_cyc);
         if (c == ovr_cyc) begin
            samples_in = '1;
            ch_enable  = 4'b0001;
         end
         unit_idle = !(c >= idle_a && c <= idle_b);
         mid();
         if (busy) busycnt++;
         if (unit_start) begin
            if (nstart < 4) chseq[2*nstart +: 2] = unit_chan;
            if (nstart == 0) op0 = unit_operand;
            st.push_back(c);
            nstart++;
         end else if (busy && unit_chan == 2'd2) begin
            wf2++;
         end
         if (results_valid) begin
            vcyc = c;
            break;
         end
      end
      step();
      sample_ready = 1'b0;
      clear_err    = 1'b0;
      unit_idle    = 1'b1;
   endtask

   initial begin
      // reset state
      step(); step();
      RESET = 1'b0;
      step();
      mid();
      check("rst_ctl", {unit_start, results_valid, busy, overrun,
                        timeout_err}, 5'b0);
      check("rst_unit", {unit_operand, unit_chan}, 34'h0);
      check("rst_res", results_out, 128'h0);

      // all channels enabled
      run_frame({32'h44, 32'h33, 32'h22, 32'h11}, 4'b1111, 40);
      mid();
      check("t1_vcyc", vcyc, 17);
      check("t1_chseq", chseq, 8'hE4);
      check("t1_starts", {st_at(0), st_at(1), st_at(2), st_at(3)},
            {32'd1, 32'd5, 32'd9, 32'd13});
      check("t1_op0", op0, 32'h11);
      check("t1_busy", busycnt, 17);
      check("t1_res", results_out, {32'h88, 32'h66, 32'h44, 32'h22});
      check("t1_idle", busy, 1'b0);

      // sparse mask
      run_frame({32'hD0, 32'hC0, 32'hB0, 32'hA0}, 4'b1010, 40);
      mid();
      check("t2_vcyc", vcyc, 9);
      check("t2_n", nstart, 2);
      check("t2_chseq", chseq[3:0], 4'hD);
      check("t2_starts", {st_at(0), st_at(1)}, {32'd1, 32'd5});
      check("t2_res", results_out, {32'h1A0, 32'h66, 32'h160, 32'h22});

      // zero mask
      run_frame({32'h9, 32'h9, 32'h9, 32'h9}, 4'b0000, 40);
      mid();
      check("t3_vcyc", vcyc, 1);
      check("t3_n", nstart, 0);
      check("t3_res", results_out, {32'h1A0, 32'h66, 32'h160, 32'h22});

      // backpressure: unit_idle low for 5 cycles
      idle_a = 1; idle_b = 5;
      run_frame({32'h0, 32'h0, 32'h0, 32'h5}, 4'b0001, 40);
      idle_a = -1; idle_b = -1;
      mid();
      check("t3b_start", st_at(0), 6);
      check("t3b_vcyc", vcyc, 10);
      check("t3b_res", results_out, {32'h1A0, 32'h66, 32'h160, 32'h0A});

      // watchdog on channel 2
      sup_en = 1'b1;
      run_frame({32'h4, 32'h3, 32'h2, 32'h1}, 4'b1111, 60);
      sup_en = 1'b0;
      mid();
      check("t4_wait2", wf2, 8);
      check("t4_start3", st_at(3), 18);
      check("t4_vcyc", vcyc, 22);
      check("t4_res", results_out, {32'h8, 32'h66, 32'h4, 32'h2});
      check("t4_errs", {timeout_err, overrun}, 2'b10);
      step();
      f_fin = 1'b1;
      f_res = 32'hDEAD;
      step();
      f_fin = 1'b0;
      mid();
      check("t4_late", {busy, results_out},
            {1'b0, 32'h8, 32'h66, 32'h4, 32'h2});
      step();
      clear_err = 1'b1;
      step();
      clear_err = 1'b0;
      mid();
      check("t4_clr", timeout_err, 1'b0);

      // overrun mid-frame
      ovr_cyc = 6;
      run_frame({32'h400, 32'h300, 32'h200, 32'h100}, 4'b1111, 40);
      mid();
      check("t5_ovr", overrun, 1'b1);
      check("t5_n", nstart, 4);
      check("t5_vcyc", vcyc, 17);
      check("t5_res", results_out, {32'h800, 32'h600, 32'h400, 32'h200});
      step();
      clear_err = 1'b1;
      step();
      clear_err = 1'b0;
      mid();
      check("t5_clr", overrun, 1'b0);

      // overrun in DONE colliding with clear_err
      ovr_cyc = 17;
      ovr_clr = 1'b1;
      run_frame({32'h400, 32'h300, 32'h200, 32'h100}, 4'b1111, 40);
      ovr_cyc = -1;
      ovr_clr = 1'b0;
      mid();
      check("t5_coll", {overrun, busy}, 2'b10);
      step();
      mid();
      check("t5_drop", {busy, results_out},
            {1'b0, 32'h800, 32'h600, 32'h400, 32'h200});

      // reset during WAIT_FIN of channel 1
      step();
      sample_ready = 1'b1;
      samples_in   = {32'hA, 32'h9, 32'h8, 32'h7};
      ch_enable    = 4'b1111;
      for (int c = 1; c <= 5; c++) begin
         step();
         sample_ready = 1'b0;
      end
      step();
      RESET = 1'b1;
      step();
      RESET = 1'b0;
      mid();
      check("t6_ctl", {unit_start, unit_operand, unit_chan, results_valid,
                       busy, overrun, timeout_err}, 39'h0);
      check("t6_res", results_out, 128'h0);
      step();
      step();
      mid();
      check("t6_latefin", {busy, results_out}, 129'h0);
      run_frame({32'h4, 32'h3, 32'h2, 32'h1}, 4'b1111, 40);
      mid();
      check("t6_vcyc", vcyc, 17);
      check("t6_res2", results_out, {32'h8, 32'h6, 32'h4, 32'h2});

      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule

// File: doc/gain_unit_scheduler.md
# gain_unit_scheduler

Sequences up to four audio channel samples through the single shared multi-cycle gain/volume unit, one channel at a time, using that unit's start/idle/fin handshake. It sits between the FIR filter bank outputs and the gain unit. It latches a per-frame snapshot of samples and the channel-enable mask, skips disabled channels, and guards each transaction with a watchdog. It also reports frame completion, overruns and timeouts to downstream logic and the HPS.

## Interface
- `NCH`, 4: number of channels; fixed at 4 in this design.
- `TIMEOUT`, 255: maximum WAIT_FIN cycles per channel before abort; range 1..255.

- `CLK`  in  1  clock
- `RESET`  in  1  reset, synchronous, active-high
- `sample_ready`  in  1  one-cycle pulse: new frame on `samples_in`
- `samples_in`  in  NCH*32  channel c at bits [32c+31:32c]
- `ch_enable`  in  NCH  bit c=1 processes channel c
- `clear_err`  in  1  clears sticky `overrun` and `timeout_err`
- `unit_idle`  in  1  shared unit ready to accept `unit_start`
- `unit_fin`  in  1  one-cycle pulse: `unit_result` valid
- `unit_result`  in  32  gain unit output
- `unit_start`  out  1  start pulse to the gain unit
- `unit_operand`  out  32  sample for the current channel
- `unit_chan`  out  2  index of the current channel
- `results_out`  out  NCH*32  last captured result per channel, same packing as `samples_in`
- `results_valid`  out  1  one-cycle pulse: frame complete
- `busy`  out  1  high in any state other than IDLE
- `overrun`  out  1  sticky: `sample_ready` arrived while busy
- `timeout_err`  out  1  sticky: a channel was aborted by the watchdog

## Operation
- States: IDLE, ISSUE, WAIT_FIN, DONE.
- **IDLE**
  - On `sample_ready`, latch `samples_in` into the snapshot and `ch_enable` into the mask.
  - Mask nonzero: set `ch` to the lowest enabled index and go to ISSUE.
  - Mask zero: go to DONE.
- **ISSUE**
  - Wait while `unit_idle`=0.
  - In the cycle `unit_idle`=1: assert `unit_start` combinationally for exactly that cycle, clear the watchdog, go to WAIT_FIN.
- **WAIT_FIN**
  - On `unit_fin`=1: capture `unit_result` into `results_out[ch]`.
  - Without fin: the watchdog increments each cycle. When it reaches TIMEOUT, set `timeout_err` and leave `results_out[ch]` unchanged.
  - In either case, advance to the next higher enabled channel and go to ISSUE. If none remains, go to DONE.
- **DONE**: `results_valid`=1 for one cycle, then go to IDLE.
- `unit_operand` is the snapshot of `ch`, and `unit_chan` is `ch`, in ISSUE and WAIT_FIN. Both are 0 otherwise.
- Disabled channels keep their previous `results_out` value. No arithmetic is performed on data; values are passed through 32-bit unchanged.
- `sample_ready` outside IDLE:
  - The frame is dropped and `overrun` is set.
  - Snapshot, mask and sequencing are unaffected.
  - `sample_ready` in DONE counts as overrun.
- `unit_fin` outside WAIT_FIN is ignored. This includes a late fin after a timeout.
- `clear_err` and a set condition in the same cycle: set wins.
- `unit_fin` and watchdog expiry in the same cycle: fin wins, the result is captured and no error is raised.

## Timing
- Reset values: all outputs 0, `results_out` all 0, snapshot 0, mask 0, `ch`=0, watchdog 0, state IDLE.
- Reset mid-frame aborts immediately. Any fin from the in-flight unit operation afterwards is ignored.
- Frame timing, with `sample_ready` sampled in cycle 0:
  - Cycle 1: first ISSUE.
  - If `unit_idle`=1 and fin arrives L cycles after each start, each channel takes 1+L cycles.
  - For E enabled channels, `results_valid` is high in cycle 1+E·(1+L).
  - `results_out[c]` updates in the cycle after its fin.
- Mask zero: `results_valid` in cycle 1.
- Watchdog abort: with no fin, WAIT_FIN lasts exactly TIMEOUT cycles.
- `busy` is high from cycle 1 through the DONE cycle inclusive.
- A new `sample_ready` is accepted in the cycle after DONE.

## Test plan
- **All channels enabled.** Mask 4'b1111, samples 0x11/0x22/0x33/0x44. Unit model returns 2×operand with fin L=3 after start, `unit_idle`=1.
  - `unit_chan` sequence is 0,1,2,3.
  - `results_out` = 0x22/0x44/0x66/0x88.
  - `results_valid` in cycle 17.
- **Sparse mask.** Mask 4'b1010, L=3.
  - Starts issued only for chan 1 then 3.
  - `results_out[0]` and `[2]` hold their prior values.
  - `results_valid` in cycle 9.
- **Zero mask and backpressure.**
  - Mask 0: `results_valid` in cycle 1 and no `unit_start`.
  - Separately, hold `unit_idle`=0 for 5 cycles in ISSUE: `unit_start` is delayed exactly 5 cycles.
- **Watchdog.** TIMEOUT=8; suppress fin for chan 2.
  - Chan 2 spends exactly 8 cycles in WAIT_FIN.
  - `timeout_err`=1 and `results_out[2]` is unchanged; chan 3 completes.
  - A late fin is ignored.
  - `clear_err` clears `timeout_err`.
- **Overrun and clear collision.** Pulse `sample_ready` mid-frame.
  - `overrun`=1 and the snapshot is unchanged (results match the first frame).
  - `clear_err` in the same cycle as a new overrun leaves `overrun`=1.
- **Reset mid-frame.** Assert `RESET` during WAIT_FIN of chan 1.
  - All outputs are 0 the next cycle.
  - A following fin is ignored.
  - A new frame completes normally.
